// File: rtl/fazyrv_csr_irq_if.sv
// ---------------------------------------------------------------------------
// fazyrv_csr_irq_if
// CSR access bus between the control unit (master) and the CSR unit (slave).
// One access per CSR instruction, one cycle long.
//   csr_en_i      access strobe
//   csr_op_i      01 RW, 10 RS, 11 RC, 00 read only
//   csr_wr_i      write permitted (low for RS/RC with rs1 = x0)
//   csr_addr_i    12-bit CSR address
//   csr_wdata_i   write operand
//   csr_rdata_o   old CSR value (combinational)
//   csr_illegal_o access illegal (combinational, qualified by csr_en_i)
// ---------------------------------------------------------------------------
interface fazyrv_csr_irq_if;
  logic        csr_en_i;
  logic [1:0]  csr_op_i;
  logic        csr_wr_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;

  modport master (
    output csr_en_i, csr_op_i, csr_wr_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_en_i, csr_op_i, csr_wr_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/fazyrv_csr_irq.sv
// ---------------------------------------------------------------------------
// fazyrv_csr_irq
// Machine-mode CSR unit with full CSRRW/CSRRS/CSRRC semantics, writable
// cycle/instret counters, mcountinhibit, mscratch and three prioritised
// level interrupt sources (software, timer, external).
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   csr                 CSR access bus (slave modport)
//   instret_i           one instruction retired this cycle
//   trap_i, mret_i      trap taken / mret executed this cycle
//   trap_int_i          trap is an interrupt
//   trap_code_i         exception code written into mcause
//   irq_m{s,t,e}i_i     level interrupt inputs
//   irq_pend_o          enabled interrupt pending (registered)
//   irq_code_o          code of highest-priority pending interrupt
// ---------------------------------------------------------------------------
module fazyrv_csr_irq #(
  parameter int CNTW        = 64,
  parameter int HAS_CNT     = 1,
  parameter int HAS_SCRATCH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fazyrv_csr_irq_if.slave       csr,
  input  logic                  instret_i,
  input  logic                  trap_i,
  input  logic                  mret_i,
  input  logic                  trap_int_i,
  input  logic [4:0]            trap_code_i,
  input  logic                  irq_msi_i,
  input  logic                  irq_mti_i,
  input  logic                  irq_mei_i,
  output logic                  irq_pend_o,
  output logic [3:0]            irq_code_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MCNTINH  = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRH   = 12'hC82;

  localparam bit CNT_EN  = (HAS_CNT != 0);
  localparam bit HI_EN   = (HAS_CNT != 0) && (CNTW == 64);
  localparam bit SCR_EN  = (HAS_SCRATCH != 0);

  // Architectural state
  logic            r_mstatusMie;
  logic            r_mstatusMpie;
  logic [2:0]      r_mie;          // {MEIE, MTIE, MSIE}
  logic [2:0]      r_mip;          // {MEIP, MTIP, MSIP}
  logic [31:0]     r_mscratch;
  logic            r_mcauseInt;
  logic [4:0]      r_mcauseCode;
  logic            r_cy;
  logic            r_ir;
  logic [CNTW-1:0] r_mcycle;
  logic [CNTW-1:0] r_minstret;
  logic            r_irqPend;
  logic [3:0]      r_irqCode;

  logic [31:0]     w_rdata;
  logic            w_impl;
  logic            w_illegal;
  logic [31:0]     w_wval;
  logic            w_we;
  logic [63:0]     w_cyc64;
  logic [63:0]     w_ins64;
  logic [CNTW-1:0] w_cycNext;
  logic [CNTW-1:0] w_insNext;
  logic [2:0]      w_active;
  logic            w_pend;
  logic [3:0]      w_code;

  // Counters viewed as 64 bits so word selects are legal for any CNTW.
  assign w_cyc64 = 64'(r_mcycle);
  assign w_ins64 = 64'(r_minstret);

  // Read mux and address decode; an address only counts as implemented
  // when the parameters enable the register behind it.
  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b0;
    case (csr.csr_addr_i)
      ADDR_MSTATUS: begin
        w_impl     = 1'b1;
        w_rdata[3] = r_mstatusMie;
        w_rdata[7] = r_mstatusMpie;
      end
      ADDR_MIE: begin
        w_impl      = 1'b1;
        w_rdata[3]  = r_mie[0];
        w_rdata[7]  = r_mie[1];
        w_rdata[11] = r_mie[2];
      end
      ADDR_MIP: begin
        w_impl      = 1'b1;
        w_rdata[3]  = r_mip[0];
        w_rdata[7]  = r_mip[1];
        w_rdata[11] = r_mip[2];
      end
      ADDR_MCNTINH: begin
        w_impl     = 1'b1;
        w_rdata[0] = r_cy;
        w_rdata[2] = r_ir;
      end
      ADDR_MCAUSE: begin
        w_impl       = 1'b1;
        w_rdata[31]  = r_mcauseInt;
        w_rdata[4:0] = r_mcauseCode;
      end
      ADDR_MSCRATCH: begin
        w_impl  = SCR_EN;
        w_rdata = SCR_EN ? r_mscratch : 32'h0;
      end
      ADDR_MCYCLE, ADDR_CYCLE: begin
        w_impl  = CNT_EN;
        w_rdata = CNT_EN ? w_cyc64[31:0] : 32'h0;
      end
      ADDR_MINSTRET, ADDR_INSTRET: begin
        w_impl  = CNT_EN;
        w_rdata = CNT_EN ? w_ins64[31:0] : 32'h0;
      end
      ADDR_MCYCLEH, ADDR_CYCLEH: begin
        w_impl  = HI_EN;
        w_rdata = HI_EN ? w_cyc64[63:32] : 32'h0;
      end
      ADDR_MINSTRH, ADDR_INSTRH: begin
        w_impl  = HI_EN;
        w_rdata = HI_EN ? w_ins64[63:32] : 32'h0;
      end
      default: ;
    endcase
  end

  // The 0xCxx user shadows are read-only, so any write attempt there traps.
  assign w_illegal = csr.csr_en_i &
                     (~w_impl | (csr.csr_wr_i & (csr.csr_addr_i[11:8] == 4'hC)));

  assign csr.csr_rdata_o   = w_rdata;
  assign csr.csr_illegal_o = w_illegal;

  // New value for the addressed CSR, derived from its old value.
  always_comb begin
    case (csr.csr_op_i)
      2'b01:   w_wval = csr.csr_wdata_i;
      2'b10:   w_wval = w_rdata | csr.csr_wdata_i;
      2'b11:   w_wval = w_rdata & ~csr.csr_wdata_i;
      default: w_wval = w_rdata;
    endcase
  end

  assign w_we = csr.csr_en_i & csr.csr_wr_i & (csr.csr_op_i != 2'b00) & ~w_illegal;

  // Counter next-state: a write to either word replaces the whole cycle's
  // increment, leaving the other word exactly as it was.
  always_comb begin
    w_cycNext = r_mcycle + {{(CNTW-1){1'b0}}, ~r_cy};
    if (w_we && csr.csr_addr_i == ADDR_MCYCLE)
      w_cycNext = CNTW'({w_cyc64[63:32], w_wval});
    else if (w_we && csr.csr_addr_i == ADDR_MCYCLEH)
      w_cycNext = CNTW'({w_wval, w_cyc64[31:0]});
  end

  always_comb begin
    w_insNext = r_minstret + {{(CNTW-1){1'b0}}, (instret_i & ~r_ir)};
    if (w_we && csr.csr_addr_i == ADDR_MINSTRET)
      w_insNext = CNTW'({w_ins64[63:32], w_wval});
    else if (w_we && csr.csr_addr_i == ADDR_MINSTRH)
      w_insNext = CNTW'({w_wval, w_ins64[31:0]});
  end

  // Interrupt arbitration on the registered mip: MEI beats MSI beats MTI.
  assign w_active = r_mie & r_mip;
  assign w_pend   = r_mstatusMie & (|w_active);

  always_comb begin
    w_code = 4'd0;
    if (w_pend) begin
      if (w_active[2])      w_code = 4'd11;
      else if (w_active[0]) w_code = 4'd3;
      else                  w_code = 4'd7;
    end
  end

  // All state updates. mstatus and mcause give trap priority over mret,
  // and both over a CSR write in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mstatusMie  <= 1'b0;
      r_mstatusMpie <= 1'b0;
      r_mie         <= '0;
      r_mip         <= '0;
      r_mscratch    <= '0;
      r_mcauseInt   <= 1'b0;
      r_mcauseCode  <= '0;
      r_cy          <= 1'b0;
      r_ir          <= 1'b0;
      r_mcycle      <= '0;
      r_minstret    <= '0;
      r_irqPend     <= 1'b0;
      r_irqCode     <= '0;
    end else begin
      r_mip      <= {irq_mei_i, irq_mti_i, irq_msi_i};
      r_irqPend  <= w_pend;
      r_irqCode  <= w_code;
      r_mcycle   <= w_cycNext;
      r_minstret <= w_insNext;

      if (trap_i) begin
        r_mstatusMpie <= r_mstatusMie;
        r_mstatusMie  <= 1'b0;
      end else if (mret_i) begin
        r_mstatusMie  <= r_mstatusMpie;
        r_mstatusMpie <= 1'b1;
      end else if (w_we && csr.csr_addr_i == ADDR_MSTATUS) begin
        r_mstatusMie  <= w_wval[3];
        r_mstatusMpie <= w_wval[7];
      end

      if (trap_i) begin
        r_mcauseInt  <= trap_int_i;
        r_mcauseCode <= trap_code_i;
      end else if (w_we && csr.csr_addr_i == ADDR_MCAUSE) begin
        r_mcauseInt  <= w_wval[31];
        r_mcauseCode <= w_wval[4:0];
      end

      if (w_we && csr.csr_addr_i == ADDR_MIE)
        r_mie <= {w_wval[11], w_wval[7], w_wval[3]};

      if (w_we && csr.csr_addr_i == ADDR_MCNTINH) begin
        r_cy <= w_wval[0];
        r_ir <= w_wval[2];
      end

      if (w_we && csr.csr_addr_i == ADDR_MSCRATCH)
        r_mscratch <= w_wval;
    end
  end

  assign irq_pend_o = r_irqPend;
  assign irq_code_o = r_irqCode;

endmodule
